// File: rtl/fht_rd_unload_if.sv
// Bundle of start/config, RAM read-port and output-stream signals for the FHT bank unloader.
// No logic of its own; the unloader sits on the master side, the RAM/sink on the slave side.
// Stream uses valid/ready, RAM side is a fixed-latency read with no handshake.
interface fht_rd_unload_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
);
  logic                    iSTART;
  logic                    iBIT_REV;
  logic [A_BIT-1:0]        oADDR_RD_0;
  logic [A_BIT-1:0]        oADDR_RD_1;
  logic [A_BIT-1:0]        oADDR_RD_2;
  logic [A_BIT-1:0]        oADDR_RD_3;
  logic signed [D_BIT-1:0] iDATA_0;
  logic signed [D_BIT-1:0] iDATA_1;
  logic signed [D_BIT-1:0] iDATA_2;
  logic signed [D_BIT-1:0] iDATA_3;
  logic signed [D_BIT-1:0] oDATA;
  logic [A_BIT+1:0]        oIDX;
  logic                    oVALID;
  logic                    iREADY;
  logic                    oLAST;
  logic                    oBUSY;
  logic                    oDONE;

  modport master (
    input  iSTART, iBIT_REV, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
  );

  modport slave (
    output iSTART, iBIT_REV, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
  );
endinterface

// File: rtl/fht_rd_unload.sv
// Reads the four FHT result banks line by line and emits the samples as one ordered stream.
// First beat RD_LAT cycles after start; each line costs RD_LAT idle cycles plus 4 beats.
// Backpressure: oDATA/oIDX/oLAST hold while oVALID & !iREADY; RAM reads stall with the stream.
module fht_rd_unload #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 2
) (
  input logic           iCLK,
  input logic           iRESET,
  fht_rd_unload_if.master bus
);

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CW-1:0]    LAT_LAST = CW'(RD_LAT - 1);
  localparam logic [A_BIT-1:0] J_LAST   = {A_BIT{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_EMIT} state_t;

  state_t                  state, state_n;
  logic [A_BIT-1:0]        j, j_n;
  logic [1:0]              b, b_n;
  logic                    brev, brev_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [A_BIT-1:0]        addr, addr_n;
  logic                    done, done_n;
  logic                    cap;
  logic signed [D_BIT-1:0] bufw [4];

  // Line counter to RAM line: bit-reversed in reverse mode, identity otherwise.
  function automatic logic [A_BIT-1:0] line_addr(input logic [A_BIT-1:0] jj, input logic rev);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < A_BIT; i++) r[i] = jj[A_BIT-1-i];
    return rev ? r : jj;
  endfunction

  // Next-state logic: address issue, read-latency wait, 4-beat emit per line.
  always_comb begin
    state_n = state;
    j_n     = j;
    b_n     = b;
    brev_n  = brev;
    cnt_n   = cnt;
    addr_n  = addr;
    done_n  = 1'b0;
    cap     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.iSTART) begin
          j_n     = '0;
          b_n     = '0;
          brev_n  = bus.iBIT_REV;
          addr_n  = line_addr('0, bus.iBIT_REV);
          cnt_n   = '0;
          state_n = S_WAIT;
        end
      end
      S_ADDR: begin
        addr_n  = line_addr(j, brev);
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == LAT_LAST) begin
          cap     = 1'b1;
          b_n     = '0;
          state_n = S_EMIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.iREADY) begin
          if (b != 2'd3) begin
            b_n = b + 2'd1;
          end else if (j != J_LAST) begin
            // Next line's address goes out on the same edge that takes the 4th beat.
            j_n     = j + 1'b1;
            addr_n  = line_addr(j + 1'b1, brev);
            cnt_n   = '0;
            state_n = S_WAIT;
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= S_IDLE;
      j     <= '0;
      b     <= '0;
      brev  <= 1'b0;
      cnt   <= '0;
      addr  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      j     <= j_n;
      b     <= b_n;
      brev  <= brev_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      done  <= done_n;
    end
  end

  // Line buffer: one word per bank, loaded when the read data becomes valid.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i < 4; i++) bufw[i] <= '0;
    end else if (cap) begin
      bufw[0] <= bus.iDATA_0;
      bufw[1] <= bus.iDATA_1;
      bufw[2] <= bus.iDATA_2;
      bufw[3] <= bus.iDATA_3;
    end
  end

  assign bus.oADDR_RD_0 = addr;
  assign bus.oADDR_RD_1 = addr;
  assign bus.oADDR_RD_2 = addr;
  assign bus.oADDR_RD_3 = addr;
  assign bus.oDATA      = bufw[b];
  assign bus.oIDX       = {j, b};
  assign bus.oVALID     = (state == S_EMIT);
  assign bus.oLAST      = (state == S_EMIT) && (j == J_LAST) && (b == 2'd3);
  assign bus.oBUSY      = (state != S_IDLE);
  assign bus.oDONE      = done;

endmodule

// File: tb/tb_fht_rd_unload.sv
module tb_fht_rd_unload;
  localparam int D_BIT = 16;
  localparam int A_BIT = 3;
  localparam int NI    = 3;

  typedef struct packed {
    logic signed [15:0] data;
    logic [4:0]         idx;
    logic               last;
    logic [2:0]         addr;
  } beat_t;

  typedef struct {
    string name;
    int    inst;
    bit    brev;
    bit    rnd;
    bit    poke;
    int    exp_first;
    int    exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_v [NI];
  logic bit_rev;
  logic ready;

  logic               mon_valid [NI];
  logic               mon_last  [NI];
  logic               mon_busy  [NI];
  logic               mon_done  [NI];
  logic signed [15:0] mon_data  [NI];
  logic [4:0]         mon_idx   [NI];
  logic [2:0]         mon_addr  [NI][4];

  int    n_vec = 0;
  int    n_err = 0;
  int    done_cnt [NI];
  beat_t exp_q [$];

  always #5 clk = ~clk;

  // One DUT per read latency (1, 2, 3), each with its own RAM model.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = g + 1;
    fht_rd_unload_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();
    logic [2:0] ra [4];
    logic [2:0] rd [4];

    assign bus.iSTART   = start_v[g];
    assign bus.iBIT_REV = bit_rev;
    assign bus.iREADY   = ready;
    assign ra[0] = bus.oADDR_RD_0;
    assign ra[1] = bus.oADDR_RD_1;
    assign ra[2] = bus.oADDR_RD_2;
    assign ra[3] = bus.oADDR_RD_3;

    if (LAT == 1) begin : g_l1
      for (genvar i = 0; i < 4; i++) begin : g_b
        assign rd[i] = ra[i];
      end
    end else begin : g_ln
      logic [2:0] dly [4][LAT-1];
      always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
          dly[i][0] <= ra[i];
          for (int s = 1; s < LAT - 1; s++) dly[i][s] <= dly[i][s-1];
        end
      end
      for (genvar i = 0; i < 4; i++) begin : g_b
        assign rd[i] = dly[i][LAT-2];
      end
    end

    // Line L bank i holds 4L+i.
    assign bus.iDATA_0 = {11'd0, rd[0], 2'd0};
    assign bus.iDATA_1 = {11'd0, rd[1], 2'd1};
    assign bus.iDATA_2 = {11'd0, rd[2], 2'd2};
    assign bus.iDATA_3 = {11'd0, rd[3], 2'd3};

    fht_rd_unload #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(LAT)) dut (
      .iCLK   (clk),
      .iRESET (rst),
      .bus    (bus)
    );

    assign mon_valid[g]   = bus.oVALID;
    assign mon_last[g]    = bus.oLAST;
    assign mon_busy[g]    = bus.oBUSY;
    assign mon_done[g]    = bus.oDONE;
    assign mon_data[g]    = bus.oDATA;
    assign mon_idx[g]     = bus.oIDX;
    assign mon_addr[g][0] = bus.oADDR_RD_0;
    assign mon_addr[g][1] = bus.oADDR_RD_1;
    assign mon_addr[g][2] = bus.oADDR_RD_2;
    assign mon_addr[g][3] = bus.oADDR_RD_3;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of a whole 32-sample frame.
  task automatic push_frame(input bit brev);
    int    brtab [8];
    beat_t e;
    int    line;
    brtab = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int k = 0; k < 32; k++) begin
      line   = brev ? brtab[k / 4] : k / 4;
      e.data = 16'(4 * line + (k % 4));
      e.idx  = 5'(k);
      e.last = (k == 31);
      e.addr = 3'(line);
      exp_q.push_back(e);
    end
  endtask

  // Checks each transfer against the scoreboard and output stability under backpressure.
  task automatic monitor();
    logic               hold [NI];
    logic signed [15:0] hd   [NI];
    logic [4:0]         hi   [NI];
    logic               hl   [NI];
    beat_t              e;
    for (int n = 0; n < NI; n++) hold[n] = 1'b0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
        if (rst) begin
          hold[n] = 1'b0;
          continue;
        end
        if (mon_done[n]) done_cnt[n]++;
        if (hold[n]) begin
          chk("hold_valid", mon_valid[n], 1);
          chk("hold_data", mon_data[n], hd[n]);
          chk("hold_idx", mon_idx[n], hi[n]);
          chk("hold_last", mon_last[n], hl[n]);
        end
        hold[n] = mon_valid[n] && !ready;
        hd[n]   = mon_data[n];
        hi[n]   = mon_idx[n];
        hl[n]   = mon_last[n];
        if (mon_valid[n] && ready) begin
          chk("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", mon_data[n], e.data);
            chk("beat_idx", mon_idx[n], e.idx);
            chk("beat_last", mon_last[n], e.last);
            for (int i = 0; i < 4; i++) chk("beat_addr", mon_addr[n][i], e.addr);
          end
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int first;
    int done_at;
    n       = v.inst;
    first   = -1;
    done_at = -1;
    push_frame(v.brev);
    done_cnt[n] = 0;
    @(posedge clk); #1;
    bit_rev    = v.brev;
    start_v[n] = 1'b1;
    ready      = 1'b1;
    @(posedge clk); #1;
    start_v[n] = 1'b0;
    bit_rev    = ~v.brev;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (first < 0 && mon_valid[n]) first = i;
      if (mon_done[n]) begin
        done_at = i;
        break;
      end
      if (v.poke && mon_valid[n] && (mon_idx[n] == 5'd10 || mon_last[n])) start_v[n] = 1'b1;
      @(posedge clk); #1;
      start_v[n] = 1'b0;
      if (v.rnd) ready = 1'($urandom_range(0, 1));
    end
    start_v[n] = 1'b0;
    ready      = 1'b1;
    chk({v.name, "_first_valid"}, first, v.exp_first);
    if (v.exp_done >= 0) chk({v.name, "_done_cycle"}, done_at, v.exp_done);
    else chk({v.name, "_done_seen"}, done_at >= 0, 1);
    repeat (20) @(negedge clk);
    chk({v.name, "_done_pulses"}, done_cnt[n], 1);
    chk({v.name, "_sb_drained"}, exp_q.size(), 0);
    chk({v.name, "_idle_busy"}, mon_busy[n], 0);
    chk({v.name, "_idle_valid"}, mon_valid[n], 0);
    chk({v.name, "_addr_hold"}, mon_addr[n][0], 7);
  endtask

  initial begin
    vec_t tab [6];
    vec_t rv;
    bit   found;
    tab[0] = '{"ramp",     1, 1'b0, 1'b0, 1'b0, 2, 48};
    tab[1] = '{"bitrev",   1, 1'b1, 1'b0, 1'b0, 2, 48};
    tab[2] = '{"backpres", 1, 1'b0, 1'b1, 1'b0, 2, -1};
    tab[3] = '{"busystrt", 1, 1'b0, 1'b0, 1'b1, 2, 48};
    tab[4] = '{"lat1",     0, 1'b0, 1'b0, 1'b0, 1, 40};
    tab[5] = '{"lat3",     2, 1'b0, 1'b0, 1'b0, 3, 56};

    ready   = 1'b1;
    bit_rev = 1'b0;
    for (int n = 0; n < NI; n++) begin
      start_v[n]  = 1'b0;
      done_cnt[n] = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      chk("rst_valid", mon_valid[n], 0);
      chk("rst_busy", mon_busy[n], 0);
      chk("rst_done", mon_done[n], 0);
      chk("rst_last", mon_last[n], 0);
      chk("rst_data", mon_data[n], 0);
      chk("rst_idx", mon_idx[n], 0);
      for (int i = 0; i < 4; i++) chk("rst_addr", mon_addr[n][i], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) run_vec(tab[t]);

    // Asynchronous reset in the middle of a frame, then a clean restart.
    push_frame(1'b0);
    @(posedge clk); #1;
    bit_rev    = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mon_valid[1] && mon_idx[1] == 5'd13) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_beat13_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", mon_valid[1], 0);
    chk("midrst_busy", mon_busy[1], 0);
    chk("midrst_idx", mon_idx[1], 0);
    chk("midrst_last", mon_last[1], 0);
    for (int i = 0; i < 4; i++) chk("midrst_addr", mon_addr[1][i], 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("postrst_busy", mon_busy[1], 0);
    chk("postrst_valid", mon_valid[1], 0);
    rv = tab[0];
    rv.name = "restart";
    run_vec(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fht_rd_unload.md
# fht_rd_unload

Unloads the four FHT result RAM banks after a transform completes and presents the samples as a single ordered stream with a valid/ready handshake. The block drives the `fht_top` read ports (`iADDR_RD_0..3`) and consumes `oDATA_0..3`. It is the reader counterpart of the four-bank ADC writer. Sample `k` lives at bank `k[1:0]`, line `k >> 2`. An optional bit-reverse mode restores natural order from the FHT bit-reversed line order.

## Interface

Parameters:
- `D_BIT`, default 16: RAM word width (signed).
- `A_BIT`, default 8: line address width. `BANK_SIZE = 2**A_BIT`; frame length is `4*BANK_SIZE` samples.
- `RD_LAT`, default 2: RAM read latency in clocks, from address register update to data valid on `iDATA_x`. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `iCLK`, in, 1: clock.
- `iRESET`, in, 1: asynchronous, active-high reset.
- `iSTART`, in, 1: one-cycle request to unload a frame.
- `iBIT_REV`, in, 1: latched at start. 1 means the line address is the bit-reverse of the line counter.
- `oADDR_RD_0..3`, out, A_BIT each: RAM read addresses. All four always carry the same value.
- `iDATA_0..3`, in, D_BIT each: RAM read data.
- `oDATA`, out, D_BIT: stream sample.
- `oIDX`, out, A_BIT+2: natural index `k` of the current `oDATA` (counter value, not the bit-reversed value).
- `oVALID`, out, 1: `oDATA`/`oIDX` valid.
- `iREADY`, in, 1: sink accepts. A beat transfers on a clock edge where `oVALID & iREADY`.
- `oLAST`, out, 1: high with the beat where `k = 4*BANK_SIZE-1`.
- `oBUSY`, out, 1: a frame is in progress.
- `oDONE`, out, 1: one-cycle pulse at frame end.

## Operation

FSM states: IDLE, ADDR, WAIT, EMIT.

- **IDLE**
  - `iSTART=1`: clear line counter `j` and beat counter `b`, latch `iBIT_REV`, register address `A(j)`, set `oBUSY`, go to WAIT.
  - `iSTART=0`: stay.
- **ADDR**
  - Register `A(j)` on all four address outputs, go to WAIT.
- **WAIT**
  - Count `RD_LAT` cycles from the address update.
  - On the final count edge, capture `iDATA_0..3` into a 4-word buffer, set `b=0`, go to EMIT.
- **EMIT**
  - `oDATA = buf[b]`, `oIDX = {j,b}`, `oVALID=1`.
  - On an edge with `iREADY=1`:
    - If `b<3`: `b++`.
    - If `b=3` and `j<BANK_SIZE-1`: `j++`, register the next `A(j)` on the same edge (ADDR is merged into this transition), go to WAIT.
    - If `b=3` and `j=BANK_SIZE-1`: go to IDLE, pulse `oDONE`, clear `oBUSY`.

Address mapping:
- Normal mode: `A(j) = j`.
- Bit-reverse mode: `A(j) = bitrev_A_BIT(j)`.
- Example (`A_BIT=8`): `j=1` reads line 128; `j=3` reads line 192.

Data handling:
- Words pass through unmodified and stay signed; no arithmetic.
- The bank index is never reversed.

Boundary rules:
- `iSTART` while `oBUSY=1` is ignored, including on the edge that accepts the last beat.
- A new `iSTART` is accepted no earlier than the cycle in which `oDONE` is high.
- Under backpressure, `oDATA`, `oIDX` and `oLAST` hold stable while `oVALID=1 & iREADY=0`.
- `oVALID` never drops without a transfer.
- `iREADY` is ignored outside EMIT.
- `oADDR_RD_x` hold the last address in IDLE.

Reset (asynchronous; outputs go to these values immediately, mid-frame included):
- State IDLE.
- `oVALID`, `oLAST`, `oBUSY`, `oDONE` = 0.
- `oDATA`, `oIDX`, `oADDR_RD_x`, counters, buffer = 0.
- No partial frame resumes after reset release.

## Timing

- The start is accepted at edge T0; `oADDR_RD_x = A(0)` from T0.
- Buffer capture at edge T0+RD_LAT; `oVALID=1` from that edge (first-beat latency = RD_LAT cycles).
- Each line takes 4 beats plus RD_LAT idle cycles with `oVALID=0` before the next line.
- With `iREADY` held high, a frame takes `BANK_SIZE*(RD_LAT+4)` cycles from T0 to the edge accepting the last beat.
- `oDONE=1` and `oBUSY=0` in the cycle after the edge accepting the last beat.
- `oLAST` is combinationally coincident with the last beat's `oVALID`.

## Test plan

- **Ramp, normal order:** `A_BIT=3`, `RD_LAT=2`, RAM line `j` bank `i` holds `4j+i`, `iREADY=1`, pulse `iSTART` with `iBIT_REV=0`. Expect `oDATA = oIDX = 0..31` in order, first `oVALID` 2 cycles after start, `oLAST` on 31, `oDONE` at cycle 48 after T0.
- **Bit-reverse:** same RAM, `iBIT_REV=1`. Expect address sequence 0,4,2,6,1,5,3,7; beat `k=4` outputs 16, beat `k=5` outputs 17; `oIDX` still 0..31.
- **Backpressure:** pseudo-random `iREADY` (50%). Expect identical data sequence to the ramp test, `oDATA` stable whenever `oVALID & !iREADY`, no dropped or duplicated `oIDX`.
- **Start while busy:** pulse `iSTART` at beat 10 and on the last-beat edge. Expect the frame unchanged, exactly one `oDONE`, and the block stays IDLE afterwards.
- **Reset mid-frame:** assert `iRESET` asynchronously (between edges) at beat 13. Expect `oVALID`, `oBUSY`, `oADDR_RD_x` at 0 immediately. Then release reset and start again: expect `oIDX` restarts at 0 and the full 32-beat frame completes.
- **Latency sweep:** `RD_LAT=1` and `RD_LAT=3` with the ramp. Expect correct data and first-valid latency equal to RD_LAT; total frame length 40 and 56 cycles respectively.
